voice_gate: RTL and testbench
=============================

# voice_gate

Noise gate with envelope follower and soft attack/release gain ramp, sitting between the codec right-channel record sample (`RightRecData[23:8]`) and the FIR / pitch-change stages in the audio path. It runs on `sys_clk`, advances once per `ready` strobe (one-cycle pulse per codec frame), and outputs a gain-scaled sample with a one-cycle `valid`. It keeps room and mic hiss out of the voice changer when nobody is speaking.

## Interface
Parameters:
- `OPEN_TH`, 16'd1024: envelope level at or above which the gate opens (unsigned magnitude).
- `CLOSE_TH`, 16'd512: envelope level below which OPEN starts the hold. Must be less than `OPEN_TH`.
- `HOLD_SAMPLES`, 12'd2400: samples held open after the envelope drops (50 ms at 48 kHz).
- `ATTACK_STEP`, 9'd8: gain increment per sample in ATTACK.
- `RELEASE_STEP`, 9'd1: gain decrement per sample in RELEASE.
- `ENV_SHIFT`, 4: envelope smoothing shift.

Ports:
- `clk` in 1: system clock (`sys_clk`).
- `reset` in 1: synchronous, active-high.
- `ready` in 1: one-cycle new-sample strobe.
- `SampleIn` in 16: signed two's-complement sample, sampled when `ready`=1.
- `enable` in 1: 0 puts the block in bypass.
- `SampleOut` out 16: signed gated sample.
- `valid` out 1: one-cycle pulse when `SampleOut` updates.
- `gate_open` out 1: high in ATTACK, OPEN and HOLD.

## Operation
- Stage 1 (cycle with `ready`=1):
  - `x_r <= SampleIn`.
  - `abs_r <= |SampleIn|`; -32768 saturates to 32767.
- Stage 2:
  - Envelope: `env <= env + ((abs_r - env) >>> ENV_SHIFT)`. The difference is a 17-bit signed value; the shift is arithmetic (floor). `env` is 16-bit unsigned and never exceeds 32767.
  - The FSM evaluates using the newly computed `env` value (combinational next-env) and updates `state`, `gain` (9-bit, 0..256) and `hold_cnt`.
- FSM, one step per sample:
  - CLOSED (`gain`=0): `env`≥`OPEN_TH` → ATTACK.
  - ATTACK: `gain` += `ATTACK_STEP`, saturating at 256. On reaching 256 → OPEN.
  - OPEN (`gain`=256): `env`<`CLOSE_TH` → HOLD and load `hold_cnt`=`HOLD_SAMPLES`.
  - HOLD: if `env`≥`OPEN_TH` → OPEN. Otherwise decrement `hold_cnt`; when it is 0 → RELEASE.
  - RELEASE: if `env`≥`OPEN_TH` → ATTACK, keeping the current gain. Otherwise `gain` -= `RELEASE_STEP`, floored at 0; on reaching 0 → CLOSED.
- Stage 3: `SampleOut <= (x_d * gain) >>>` 8, arithmetic floor. The product is 16×9 signed → 25 bits; take bits [23:8]. With `gain`=256 the output equals `x_d` exactly.
- `enable`=0:
  - `state` is forced to OPEN and `gain` to 256, so output equals input.
  - `env` keeps tracking.
  - When `enable` returns to 1, the FSM resumes from OPEN.

## Timing
- Latency: `valid` is high exactly 2 cycles after the `ready` cycle. `SampleOut` holds its value between `valid` pulses.
- Fully pipelined: back-to-back `ready` pulses are accepted every cycle. Each sample's output uses the gain computed from that same sample's FSM step.
- `ready`=0: no state, env, counter or output change.
- Reset values (synchronous): `state`=CLOSED, `gain`=0, `env`=0, `hold_cnt`=0, pipeline valids=0, `SampleOut`=0, `valid`=0, `gate_open`=0.
- Reset mid-pipeline: in-flight samples are discarded and no `valid` is produced for them.
- `reset` and `ready` high together: reset wins and the sample is dropped.
- `gate_open` is registered from `state` and updates in the same cycle as `state`.

## Structure
- `voice_gate_pkg`: state enum (CLOSED, ATTACK, OPEN, HOLD, RELEASE), `GAIN_UNITY`=9'd256, `GAIN_W`=9, `SAMPLE_W`=16.
- One sub-module, `env_follower`: abs + saturation + smoothing register, with `ENV_SHIFT` as a parameter. FSM, gain and multiply stay in `voice_gate`.

## Test plan
- Reset then 100 samples of 0 → `SampleOut`=0, `valid` every 2 cycles after `ready`, `gate_open`=0.
- Constant 16000 input → after `env` crosses 1024, ATTACK reaches 256 in 32 samples; output ramps 0, 500, 1000, … and settles at exactly 16000.
- Drop input to 0 while OPEN → HOLD lasts 2400 samples at full gain, then RELEASE spans 256 samples down to 0, then `gate_open`=0.
- Burst of 16000 during RELEASE with gain=100 → ATTACK from 100 upward, never dropping through 0.
- Input -32768 with gain 256 → `SampleOut`=-32768; `env` saturates at ≤32767.
- `enable`=0 with tiny input 50 → output 50 with 2-cycle latency; `reset` asserted with a sample in flight → no `valid`, all outputs 0.

Source files
------------

// File: rtl/voice_gate_pkg.sv
// Shared types and constants for the voice noise gate.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package voice_gate_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 9;

    // Unity gain in Q1.8: 256 passes the sample through unchanged.
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_e;

    // Gain increment that clips at unity instead of overshooting.
    function automatic logic [GAIN_W-1:0] gain_sat_add(input logic [GAIN_W-1:0] g,
                                                       input logic [GAIN_W-1:0] step);
        logic [GAIN_W:0] sum;
        sum = {1'b0, g} + {1'b0, step};
        return (sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : GAIN_W'(sum);
    endfunction

    // Gain decrement that floors at zero instead of wrapping.
    function automatic logic [GAIN_W-1:0] gain_sat_sub(input logic [GAIN_W-1:0] g,
                                                       input logic [GAIN_W-1:0] step);
        return (g <= step) ? '0 : (g - step);
    endfunction

endpackage

// File: rtl/voice_gate_env.sv
// Envelope follower: |sample| (saturated to 32767) then one-pole smoothing.
// Latency: abs registered on the sample strobe, envelope one cycle later.
// Backpressure: none; accepts a new sample every cycle.
module env_follower
    import voice_gate_pkg::*;
#(
    parameter int ENV_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       smp_vld_i,
    input  logic signed [SAMPLE_W-1:0] smp_dat_i,
    output logic                       abs_vld_o,
    output logic        [SAMPLE_W-1:0] env_o,
    output logic        [SAMPLE_W-1:0] env_d_o
);

    logic        [SAMPLE_W-1:0] abs_d;
    logic        [SAMPLE_W-1:0] abs_q;
    logic                       abs_vld_q;
    logic        [SAMPLE_W-1:0] env_q;
    logic signed [SAMPLE_W:0]   diff_d;
    logic signed [SAMPLE_W:0]   step_d;
    logic signed [SAMPLE_W:0]   sum_d;

    // Magnitude; the most negative code has no positive twin, so clip it.
    always_comb begin
        abs_d = smp_dat_i;
        if (smp_dat_i == 16'sh8000) begin
            abs_d = 16'h7fff;
        end else if (smp_dat_i[SAMPLE_W-1]) begin
            abs_d = SAMPLE_W'(-smp_dat_i);
        end
    end

    // Both operands are <= 32767, so the 17-bit difference and sum never overflow
    // and the result stays between env and abs, i.e. within 0..32767.
    assign diff_d  = $signed({1'b0, abs_q}) - $signed({1'b0, env_q});
    assign step_d  = diff_d >>> ENV_SHIFT;
    assign sum_d   = $signed({1'b0, env_q}) + step_d;
    assign env_d_o = SAMPLE_W'(sum_d);

    // Stage 1 captures the magnitude; stage 2 commits the smoothed envelope.
    always_ff @(posedge clk) begin
        if (reset) begin
            abs_q     <= '0;
            abs_vld_q <= 1'b0;
            env_q     <= '0;
        end else begin
            abs_vld_q <= smp_vld_i;
            if (smp_vld_i) begin
                abs_q <= abs_d;
            end
            if (abs_vld_q) begin
                env_q <= env_d_o;
            end
        end
    end

    assign abs_vld_o = abs_vld_q;
    assign env_o     = env_q;

endmodule

// File: rtl/voice_gate.sv
// Noise gate: envelope-driven FSM ramps a Q1.8 gain applied to the input sample.
// Latency: valid 2 cycles after the ready cycle; fully pipelined.
// Backpressure: none; a ready pulse every cycle is accepted.
module voice_gate
    import voice_gate_pkg::*;
#(
    parameter logic [15:0] OPEN_TH      = 16'd1024,
    parameter logic [15:0] CLOSE_TH     = 16'd512,
    parameter logic [11:0] HOLD_SAMPLES = 12'd2400,
    parameter logic [8:0]  ATTACK_STEP  = 9'd8,
    parameter logic [8:0]  RELEASE_STEP = 9'd1,
    parameter int          ENV_SHIFT    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready,
    input  logic signed [SAMPLE_W-1:0] SampleIn,
    input  logic                       enable,
    output logic signed [SAMPLE_W-1:0] SampleOut,
    output logic                       valid,
    output logic                       gate_open
);

    logic signed [SAMPLE_W-1:0] x_s1_q;
    logic signed [SAMPLE_W-1:0] x_s2_q;
    logic                       s1_vld;
    logic                       s2_vld_q;
    logic        [SAMPLE_W-1:0] env_cur;
    logic        [SAMPLE_W-1:0] env_d;

    gate_state_e                state_q;
    logic        [GAIN_W-1:0]   gain_q;
    logic        [11:0]         hold_q;
    logic                       gate_q;
    logic        [GAIN_W-1:0]   gain_att_d;
    logic        [GAIN_W-1:0]   gain_rel_d;

    logic signed [25:0]         prod_d;
    logic signed [SAMPLE_W-1:0] out_d;
    logic signed [SAMPLE_W-1:0] out_q;
    logic                       valid_q;

    env_follower #(
        .ENV_SHIFT (ENV_SHIFT)
    ) u_env (
        .clk       (clk),
        .reset     (reset),
        .smp_vld_i (ready),
        .smp_dat_i (SampleIn),
        .abs_vld_o (s1_vld),
        .env_o     (env_cur),
        .env_d_o   (env_d)
    );

    // Stage 1 holds the raw sample alongside the magnitude in the follower.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_s1_q <= '0;
        end else if (ready) begin
            x_s1_q <= SampleIn;
        end
    end

    assign gain_att_d = gain_sat_add(gain_q, ATTACK_STEP);
    assign gain_rel_d = gain_sat_sub(gain_q, RELEASE_STEP);

    // Gate FSM: one step per sample, decided on the envelope this sample produces.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLOSED;
            gain_q  <= '0;
            hold_q  <= '0;
            gate_q  <= 1'b0;
        end else if (s1_vld) begin
            if (!enable) begin
                // Bypass parks at full gain so re-enabling resumes from OPEN.
                state_q <= OPEN;
                gain_q  <= GAIN_UNITY;
                gate_q  <= 1'b1;
            end else begin
                case (state_q)
                    CLOSED: begin
                        if (env_d >= OPEN_TH) begin
                            state_q <= ATTACK;
                            gate_q  <= 1'b1;
                        end
                    end
                    ATTACK: begin
                        gain_q <= gain_att_d;
                        if (gain_att_d == GAIN_UNITY) begin
                            state_q <= OPEN;
                        end
                    end
                    OPEN: begin
                        if (env_d < CLOSE_TH) begin
                            state_q <= HOLD;
                            hold_q  <= HOLD_SAMPLES;
                        end
                    end
                    HOLD: begin
                        if (env_d >= OPEN_TH) begin
                            state_q <= OPEN;
                        end else if (hold_q <= 12'd1) begin
                            hold_q  <= '0;
                            state_q <= RELEASE;
                            gate_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 12'd1;
                        end
                    end
                    RELEASE: begin
                        // A new burst re-attacks from the current gain, not from zero.
                        if (env_d >= OPEN_TH) begin
                            state_q <= ATTACK;
                            gate_q  <= 1'b1;
                        end else begin
                            gain_q <= gain_rel_d;
                            if (gain_rel_d == '0) begin
                                state_q <= CLOSED;
                            end
                        end
                    end
                    default: begin
                        state_q <= CLOSED;
                        gain_q  <= '0;
                        gate_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stage 2 carries the sample so it meets the gain from its own FSM step.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_s2_q   <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld;
            if (s1_vld) begin
                x_s2_q <= x_s1_q;
            end
        end
    end

    // Q1.8 multiply with arithmetic floor; gain 256 reproduces the sample exactly.
    assign prod_d = x_s2_q * $signed({1'b0, gain_q});
    assign out_d  = SAMPLE_W'(prod_d >>> 8);

    // Stage 3 registers the gated sample and holds it between samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_q <= out_d;
            end
        end
    end

    assign SampleOut = out_q;
    assign valid     = valid_q;
    assign gate_open = gate_q;

endmodule

// File: tb/tb_voice_gate.sv
module tb_voice_gate;

    logic               clk;
    logic               reset;
    logic               ready;
    logic signed [15:0] SampleIn;
    logic               enable;
    logic signed [15:0] SampleOut;
    logic               valid;
    logic               gate_open;

    int checks = 0;
    int errors = 0;
    int env_m  = 0;
    logic signed [15:0] out_s;
    logic               gate_s;

    voice_gate dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .SampleIn  (SampleIn),
        .enable    (enable),
        .SampleOut (SampleOut),
        .valid     (valid),
        .gate_open (gate_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Envelope reference straight from the smoothing formula.
    function automatic int env_step(input int env, input int s);
        int a;
        a = (s < 0) ? -s : s;
        if (a > 32767) a = 32767;
        return env + ((a - env) >>> 4);
    endfunction

    // One isolated sample: ready at edge k, expect valid only after edge k+2.
    // Called and returns at a negedge.
    task automatic send(input logic signed [15:0] s);
        ready    = 1'b1;
        SampleIn = s;
        @(posedge clk);
        #1 ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("valid_early", valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("valid_k2", valid, 1);
        out_s  = SampleOut;
        gate_s = gate_open;
        env_m  = env_step(env_m, s);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        env_m = 0;
    endtask

    initial begin
        int k0;
        reset    = 1'b1;
        ready    = 1'b1;
        SampleIn = 16'sd1234;
        enable   = 1'b1;

        // Reset together with ready: reset wins, sample dropped.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", SampleOut, 0);
        chk("rst_valid", valid, 0);
        chk("rst_gate", gate_open, 0);
        reset = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_drop_valid", valid, 0);
        end

        // Silence keeps the gate closed.
        for (int i = 0; i < 100; i++) begin
            send(16'sd0);
            chk("zero_out", out_s, 0);
            chk("zero_gate", gate_s, 0);
        end

        // Constant 16000: env 1000 then 1937 opens, then 32 ramp steps of +500.
        send(16'sd16000);
        chk("att_s1_out", out_s, 0);
        chk("att_s1_gate", gate_s, 0);
        send(16'sd16000);
        chk("att_s2_out", out_s, 0);
        chk("att_s2_gate", gate_s, 1);
        for (int i = 1; i <= 32; i++) begin
            send(16'sd16000);
            chk("att_ramp_out", out_s, 500 * i);
            chk("att_ramp_gate", gate_s, 1);
        end
        for (int i = 0; i < 20; i++) begin
            send(16'sd16000);
            chk("open_out", out_s, 16000);
        end

        // Quiet input 100: stays full gain until env < 512, then 2400 hold samples.
        k0 = 0;
        for (int n = 0; n < 300 && k0 == 0; n++) begin
            send(16'sd100);
            chk("decay_out", out_s, 100);
            chk("decay_gate", gate_s, 1);
            if (env_m < 512) k0 = 1;
        end
        for (int m = 1; m <= 2400; m++) begin
            send(16'sd100);
            chk("hold_out", out_s, 100);
            chk("hold_gate", gate_s, (m < 2400) ? 1 : 0);
        end
        // Release: gain drops by 1 per sample; stop at gain 100.
        for (int j = 1; j <= 156; j++) begin
            send(16'sd100);
            chk("rel_out", out_s, (100 * (256 - j)) >>> 8);
            chk("rel_gate", gate_s, 0);
        end

        // Burst during release: re-attack from gain 100 (6250), +8 per sample.
        send(16'sd16000);
        chk("burst_out", out_s, 6250);
        chk("burst_gate", gate_s, 1);
        for (int i = 1; i <= 20; i++) begin
            int g;
            g = (100 + 8 * i > 256) ? 256 : 100 + 8 * i;
            send(16'sd16000);
            chk("reatt_out", out_s, (16000 * g) >>> 8);
            chk("reatt_gate", gate_s, 1);
        end

        // Full-scale negative at unity gain passes exactly; env clips at 32767.
        for (int i = 0; i < 3; i++) begin
            send(-16'sd32768);
            chk("neg_out", out_s, -32768);
            chk("neg_gate", gate_s, 1);
        end
        chk("env_sat", dut.env_cur, env_m);

        // No ready: output held, no valid.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_valid", valid, 0);
            chk("idle_out", SampleOut, -32768);
        end

        // Bypass from a freshly reset (closed) gate.
        do_reset();
        chk("rst2_gate", gate_open, 0);
        enable = 1'b0;
        send(16'sd50);
        chk("byp_out", out_s, 50);
        chk("byp_gate", gate_s, 1);

        // Back-to-back samples in bypass: one valid per cycle, in order.
        ready    = 1'b1;
        SampleIn = 16'sd10;
        @(posedge clk);
        #1 SampleIn = 16'sd20;
        @(posedge clk);
        #1 SampleIn = 16'sd30;
        @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        chk("b2b_v1", valid, 1);
        chk("b2b_o1", SampleOut, 10);
        @(negedge clk);
        chk("b2b_v2", valid, 1);
        chk("b2b_o2", SampleOut, 20);
        @(negedge clk);
        chk("b2b_v3", valid, 1);
        chk("b2b_o3", SampleOut, 30);
        @(negedge clk);
        chk("b2b_v4", valid, 0);
        chk("b2b_hold", SampleOut, 30);
        env_m = env_step(env_step(env_step(env_m, 10), 20), 30);

        // Re-enable: resumes from OPEN at full gain, low env moves it to HOLD.
        enable = 1'b1;
        send(16'sd50);
        chk("reen_out", out_s, 50);
        chk("reen_gate", gate_s, 1);

        // Reset with a sample in flight: no valid, outputs cleared.
        ready    = 1'b1;
        SampleIn = 16'sd1234;
        @(posedge clk);
        #1 ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_v1", valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_v2", valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_v3", valid, 0);
        chk("mid_rst_out", SampleOut, 0);
        chk("mid_rst_gate", gate_open, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_v4", valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
